// File: rtl/pc_gen.sv
// Fetch-stage program counter: offers pc to instruction memory over valid/ready,
// advances by 4 on acceptance, redirects on branch/JAL/JALR, supports halt/resume.
module pc_gen #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h100,
    parameter int               CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_ready,
    input  logic             redirect_valid,
    input  logic             redirect_jalr,
    input  logic [XLEN-1:0]  redirect_base,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             halted,
    output logic             misalign_err,
    output logic [XLEN-1:0]  bad_addr,
    output logic [CNT_W-1:0] fetch_count,
    output logic [1:0]       fsm_state
);

    // Handshake: a fetch is accepted on a rising edge where pc_valid and pc_ready are
    // both high; while pc_valid is high and not accepted, pc only changes by redirect.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [XLEN-1:0]  target_sum;
    logic [XLEN-1:0]  target;
    logic             target_misaligned;

    // Carry out of the add is discarded, so targets wrap modulo 2^XLEN.
    always_comb begin
        target_sum = redirect_jalr ? (rs1 + imm) : (redirect_base + imm);
        target     = redirect_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
        target_misaligned = (target[1:0] != 2'b00);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        count_d    = count_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    if (target_misaligned) begin
                        pc_d       = TRAP_VECTOR;
                        bad_addr_d = target;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end else if (pc_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    count_d = count_q + CNT_W'(1);
                end
                if (halt_req) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                // Redirect acts as a debug set-PC while halted; fetches are not counted.
                if (redirect_valid) begin
                    if (target_misaligned) begin
                        pc_d       = TRAP_VECTOR;
                        bad_addr_d = target;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
            count_q    <= count_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALTED);
    assign misalign_err = misalign_q;
    assign bad_addr     = bad_addr_q;
    assign fetch_count  = count_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential fetch, stall, redirects, misalign trap,
// halt/resume with debug set-PC, address wrap and reset during halt.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_ready;
    logic        redirect_valid;
    logic        redirect_jalr;
    logic [31:0] redirect_base;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic        pc_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] bad_addr;
    logic [31:0] fetch_count;
    logic [1:0]  fsm_state;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk            (clk),
        .reset          (reset),
        .pc_ready       (pc_ready),
        .redirect_valid (redirect_valid),
        .redirect_jalr  (redirect_jalr),
        .redirect_base  (redirect_base),
        .imm            (imm),
        .rs1            (rs1),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .bad_addr       (bad_addr),
        .fetch_count    (fetch_count),
        .fsm_state      (fsm_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                           input logic e_halted, input logic e_mis, input logic [31:0] e_bad,
                           input logic [31:0] e_cnt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, e_valid});
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, e_halted});
        chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, e_mis});
        chk({tag, ".bad_addr"}, bad_addr, e_bad);
        chk({tag, ".fetch_count"}, fetch_count, e_cnt);
    endtask

    task automatic set_redirect(input logic jalr, input logic [31:0] base,
                                input logic [31:0] im, input logic [31:0] r1);
        redirect_valid = 1'b1;
        redirect_jalr  = jalr;
        redirect_base  = base;
        imm            = im;
        rs1            = r1;
    endtask

    initial begin
        reset = 1'b1; pc_ready = 1'b0; redirect_valid = 1'b0; redirect_jalr = 1'b0;
        redirect_base = '0; imm = '0; rs1 = '0; halt_req = 1'b0; resume = 1'b0;

        // Reset, then BOOT cycle with pc_ready already high
        step();
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
        chk("reset.state", {30'b0, fsm_state}, 32'd0);
        reset = 1'b0; pc_ready = 1'b1;
        step();
        chk_all("boot_exit", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
        step(); chk_all("seq1", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1);
        step(); chk_all("seq2", 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'd2);
        step(); chk_all("seq3", 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 32'd3);

        // Stall: pc held while not accepted
        pc_ready = 1'b0;
        repeat (4) step();
        chk_all("stall", 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 32'd3);

        // Branch with negative offset, redirect wins over handshake
        pc_ready = 1'b1;
        set_redirect(1'b0, 32'h10, 32'hFFFF_FFF8, 32'h0);
        step(); chk_all("branch_neg", 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'd3);

        // JALR clears bit 0: 0x101 + 3 = 0x104
        set_redirect(1'b1, 32'h0, 32'h3, 32'h101);
        step(); chk_all("jalr_mask", 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 32'd3);

        // Misaligned JALR target 0x202 traps
        set_redirect(1'b1, 32'h0, 32'h2, 32'h200);
        step(); chk_all("misalign", 32'h100, 1'b1, 1'b0, 1'b1, 32'h202, 32'd3);
        redirect_valid = 1'b0; pc_ready = 1'b0;
        step(); chk_all("misalign_pulse", 32'h100, 1'b1, 1'b0, 1'b0, 32'h202, 32'd3);

        // Target add wraps: 0xFFFFFFF0 + 0x30 = 0x20
        set_redirect(1'b0, 32'hFFFF_FFF0, 32'h30, 32'h0);
        step(); chk_all("target_wrap", 32'h20, 1'b1, 1'b0, 1'b0, 32'h202, 32'd3);

        // Halt at 0x20; pc frozen despite pc_ready
        redirect_valid = 1'b0; halt_req = 1'b1;
        step(); chk_all("halt", 32'h20, 1'b0, 1'b1, 1'b0, 32'h202, 32'd3);
        halt_req = 1'b0; pc_ready = 1'b1;
        repeat (5) step();
        chk_all("halt_hold", 32'h20, 1'b0, 1'b1, 1'b0, 32'h202, 32'd3);

        // Debug set-PC while halted, then resume
        set_redirect(1'b0, 32'h40, 32'h0, 32'h0);
        step(); chk_all("halt_setpc", 32'h40, 1'b0, 1'b1, 1'b0, 32'h202, 32'd3);
        redirect_valid = 1'b0; resume = 1'b1; pc_ready = 1'b0;
        step(); chk_all("resume", 32'h40, 1'b1, 1'b0, 1'b0, 32'h202, 32'd3);
        resume = 1'b0; pc_ready = 1'b1;
        step(); chk_all("post_resume", 32'h44, 1'b1, 1'b0, 1'b0, 32'h202, 32'd4);

        // Redirect and halt in the same cycle: both take effect
        set_redirect(1'b0, 32'h80, 32'h4, 32'h0);
        halt_req = 1'b1;
        step(); chk_all("redir_halt", 32'h84, 1'b0, 1'b1, 1'b0, 32'h202, 32'd4);
        halt_req = 1'b0;

        // Misaligned debug set-PC while halted: 0x303 -> 0x302 -> trap
        set_redirect(1'b1, 32'h0, 32'h0, 32'h303);
        step(); chk_all("halt_misalign", 32'h100, 1'b0, 1'b1, 1'b1, 32'h302, 32'd4);

        // Resume and redirect together
        set_redirect(1'b0, 32'hFFFF_FFF0, 32'hC, 32'h0);
        resume = 1'b1; pc_ready = 1'b0;
        step(); chk_all("resume_redir", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h302, 32'd4);

        // Sequential wrap at top of address space
        redirect_valid = 1'b0; resume = 1'b0; pc_ready = 1'b1;
        step(); chk_all("pc_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 32'h302, 32'd5);

        // Halt then reset while halted
        halt_req = 1'b1; pc_ready = 1'b0;
        step(); chk_all("halt2", 32'h0, 1'b0, 1'b1, 1'b0, 32'h302, 32'd5);
        reset = 1'b1; halt_req = 1'b0;
        set_redirect(1'b0, 32'h500, 32'h0, 32'h0);
        step(); chk_all("reset_halt", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
        chk("reset_halt.state", {30'b0, fsm_state}, 32'd0);
        reset = 1'b0; redirect_valid = 1'b0;
        step(); chk_all("reboot", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
